nsctrl_switch_sched: RTL and testbench
======================================

NSCTRL_SWITCH_SCHED -- requirements
Module: nsctrl_switch_sched

Interface
REQ-001 The block SHALL use reset rst_n, synchronous, active-low, and clock clk_sys.
REQ-002 The block SHALL provide these ports, in this order:
- clk_sys  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- sel_req  in  1  requested control set, as a level: 0 = "_s" set, 1 = "_n" set.
- busy_s  in  1  "_s" sequencer is mid-pulse; switching is unsafe.
- busy_n  in  1  "_n" sequencer is mid-pulse; switching is unsafe.
- guard_len  in  8  blanking interval before commit, in clk_sys cycles minus 1.
- tmo_len  in  16  drain timeout in cycles; 0 disables the timeout.
- change  out  1  select for the downstream control-set mux.
- blank  out  1  forces the downstream outputs to their safe state during a switch.
- sw_busy  out  1  a switch is in progress.
- sw_done  out  1  one-cycle pulse when a switch is committed.
- sw_err  out  1  one-cycle pulse when a drain times out.

Function
REQ-003 The FSM SHALL have five states: IDLE, DRAIN, GUARD, COMMIT, HOLD.
REQ-004 In IDLE, when sel_req != change, the FSM SHALL latch target = sel_req, clear the counter, and go to DRAIN.
REQ-005 The active busy signal SHALL be busy_n when change = 1, else busy_s.
REQ-006 In DRAIN, when the active busy = 0, the FSM SHALL go to GUARD and clear the counter.
REQ-007 In DRAIN, if sel_req returns to equal change, the FSM SHALL go to IDLE with no switch and no sw_err; this abort takes priority over REQ-006.
REQ-008 In DRAIN, when tmo_len != 0 and the counter reaches tmo_len-1 with the active busy still 1, the FSM SHALL pulse sw_err for one cycle and go to HOLD.
REQ-009 In HOLD, the FSM SHALL wait until sel_req == change, then go to IDLE.
REQ-010 GUARD SHALL last exactly guard_len+1 cycles (counter 0..guard_len), then go to COMMIT; guard_len = 0 gives one cycle.
REQ-011 sel_req changes during GUARD or COMMIT SHALL be ignored; the switch completes, and IDLE then re-evaluates the mismatch.
REQ-012 The COMMIT state SHALL last one cycle; on its clock edge, change <= target and sw_done <= 1 for one cycle; the FSM then goes to IDLE.
REQ-013 blank SHALL be 1 exactly while the state is GUARD or COMMIT.
REQ-014 sw_busy SHALL be 1 while the state is DRAIN, GUARD or COMMIT.
REQ-015 Latency SHALL be as follows, when sel_req toggles before edge k and the active busy = 0:
- DRAIN at k+1.
- GUARD over k+2..k+guard_len+2.
- COMMIT at k+guard_len+3.
- change and sw_done visible at k+guard_len+4.
REQ-016 change, sw_done and sw_err SHALL be registered; busy_s and busy_n SHALL be sampled as-is, with no synchronizer, since they are on the same clk_sys domain.
REQ-017 A single 16-bit counter SHALL serve both drain timeout and guard counting; the guard compare SHALL zero-extend guard_len.

Reset
REQ-018 While rst_n = 0, at any state including mid-switch, the block SHALL set:
- state = IDLE.
- change = 0, selecting the "_s" set, consistent with the downstream mux reset.
- blank = 0, sw_busy = 0, sw_done = 0, sw_err = 0.
- counter = 0, target = 0.
REQ-019 After reset release with sel_req = 1, the block SHALL begin a normal switch sequence; it SHALL NOT jump change directly.

Structure
REQ-020 The shared package nsctrl_pkg SHALL hold:
- the FSM state enum.
- the constants GUARD_W = 8 and TMO_W = 16.
REQ-021 One sub-module, nsctrl_cnt, SHALL be used: a 16-bit counter with clear, enable, and terminal-compare against a supplied limit.
REQ-022 Total RTL SHALL be 120-400 lines, with no memories and no extra clock domains.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic switch: busy_s = 0, guard_len = 3, sel_req 0->1 before edge k -> blank high k+2..k+6; change = 1 and sw_done pulse at k+7.
- Drain wait: busy_s = 1 for 10 cycles after the request, tmo_len = 100 -> GUARD entered 1 cycle after busy_s falls; sw_err never asserted.
- Timeout: busy_n stuck at 1, change = 1, sel_req -> 0, tmo_len = 5 -> sw_err pulse after 5 DRAIN cycles; change stays 1; HOLD until sel_req = 1, then IDLE.
- Abort vs. commit: sel_req toggled back during DRAIN -> return to IDLE, no blank, no sw_done; sel_req toggled back during GUARD -> switch completes, then a second switch restores the original set.
- Reset mid-GUARD: rst_n low for 1 cycle -> change = 0 and blank = 0 next cycle; FSM in IDLE.
- Edge values: guard_len = 0 -> blank high exactly 2 cycles; tmo_len = 0 with busy stuck -> no sw_err after 70000 cycles.

Source files
------------

// File: rtl/nsctrl_pkg.sv
// Shared types and widths for the control-set switch scheduler.
// The state enum and widths are shared by the top and the bench-facing sub-blocks.
package nsctrl_pkg;

    localparam int GUARD_W = 8;
    localparam int TMO_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_GUARD,
        ST_COMMIT,
        ST_HOLD
    } sw_state_e;

endpackage

// File: rtl/nsctrl_cnt.sv
// Shared drain/guard cycle counter: clear wins over enable; hit compares the current count to limit.
// One-cycle update latency; hit is combinational from the registered count.
module nsctrl_cnt
    import nsctrl_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] limit,
    output logic             hit
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == limit);

endmodule

// File: rtl/nsctrl_switch_sched.sv
// Glitch-safe switch between the "_s" and "_n" control sets: drain the active sequencer, blank, then commit.
// With the sequencer idle, change flips guard_len+4 cycles after sel_req toggles.
module nsctrl_switch_sched
    import nsctrl_pkg::*;
(
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               sel_req,
    input  logic               busy_s,
    input  logic               busy_n,
    input  logic [GUARD_W-1:0] guard_len,
    input  logic [TMO_W-1:0]   tmo_len,
    output logic               change,
    output logic               blank,
    output logic               sw_busy,
    output logic               sw_done,
    output logic               sw_err
);

    sw_state_e state_q, state_d;
    logic      change_q, change_d;
    logic      target_q, target_d;
    logic      sw_done_q, sw_done_d;
    logic      sw_err_q, sw_err_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_hit;
    logic [TMO_W-1:0] cnt_limit;
    logic             act_busy;
    logic             tmo_en;

    // Only the sequencer driving the current set has to finish its pulse.
    assign act_busy = change_q ? busy_n : busy_s;
    assign tmo_en   = (tmo_len != '0);

    // One counter serves both phases, so the compare limit follows the state.
    assign cnt_limit = (state_q == ST_GUARD) ? {{(TMO_W-GUARD_W){1'b0}}, guard_len}
                                             : tmo_len - 1'b1;

    nsctrl_cnt u_cnt (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (cnt_limit),
        .hit     (cnt_hit)
    );

    always_comb begin
        state_d   = state_q;
        change_d  = change_q;
        target_d  = target_q;
        sw_done_d = 1'b0;
        sw_err_d  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (sel_req != change_q) begin
                    target_d = sel_req;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_en = 1'b1;
                // A withdrawn request is dropped before anything else is considered.
                if (sel_req == change_q) begin
                    state_d = ST_IDLE;
                end else if (!act_busy) begin
                    cnt_clr = 1'b1;
                    state_d = ST_GUARD;
                end else if (tmo_en && cnt_hit) begin
                    sw_err_d = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            ST_GUARD: begin
                cnt_en = 1'b1;
                if (cnt_hit) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                change_d  = target_q;
                sw_done_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_HOLD: begin
                if (sel_req == change_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            change_q  <= 1'b0;
            target_q  <= 1'b0;
            sw_done_q <= 1'b0;
            sw_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            change_q  <= change_d;
            target_q  <= target_d;
            sw_done_q <= sw_done_d;
            sw_err_q  <= sw_err_d;
        end
    end

    assign change  = change_q;
    assign sw_done = sw_done_q;
    assign sw_err  = sw_err_q;
    assign blank   = (state_q == ST_GUARD) || (state_q == ST_COMMIT);
    assign sw_busy = (state_q == ST_DRAIN) || (state_q == ST_GUARD) || (state_q == ST_COMMIT);

endmodule

// File: tb/tb_nsctrl_switch_sched.sv
// Directed and randomized bench for nsctrl_switch_sched against a phase/elapsed-time reference model.
module tb_nsctrl_switch_sched;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        sel_req;
    logic        busy_s;
    logic        busy_n;
    logic [7:0]  guard_len;
    logic [15:0] tmo_len;
    logic        change;
    logic        blank;
    logic        sw_busy;
    logic        sw_done;
    logic        sw_err;

    always #5 clk_sys = ~clk_sys;

    nsctrl_switch_sched dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .sel_req   (sel_req),
        .busy_s    (busy_s),
        .busy_n    (busy_n),
        .guard_len (guard_len),
        .tmo_len   (tmo_len),
        .change    (change),
        .blank     (blank),
        .sw_busy   (sw_busy),
        .sw_done   (sw_done),
        .sw_err    (sw_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 waiting for the sequencer,
    // 2 blanked window (guard_len+2 cycles, change flips at its end), 3 parked after timeout.
    int m_phase  = 0;
    int m_t      = 0;
    bit m_change = 1'b0;
    bit m_tgt    = 1'b0;
    bit m_done   = 1'b0;
    bit m_err    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_step();
        bit abusy;
        if (!rst_n) begin
            m_phase = 0; m_t = 0; m_change = 1'b0; m_tgt = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            abusy  = m_change ? busy_n : busy_s;
            case (m_phase)
                0: if (sel_req != m_change) begin m_tgt = sel_req; m_phase = 1; m_t = 0; end
                1: begin
                    if (sel_req == m_change) m_phase = 0;
                    else if (!abusy) begin m_phase = 2; m_t = 0; end
                    else if (tmo_len != 0 && m_t == int'(tmo_len) - 1) begin m_err = 1'b1; m_phase = 3; end
                    else m_t++;
                end
                2: begin
                    if (m_t == int'(guard_len) + 1) begin
                        m_change = m_tgt; m_done = 1'b1; m_phase = 0;
                    end else m_t++;
                end
                default: if (sel_req == m_change) m_phase = 0;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        chk("m_change", change, m_change);
        chk("m_blank", blank, m_phase == 2);
        chk("m_sw_busy", sw_busy, m_phase == 1 || m_phase == 2);
        chk("m_sw_done", sw_done, m_done);
        chk("m_sw_err", sw_err, m_err);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; sel_req = 1'b0; busy_s = 1'b0; busy_n = 1'b0;
        guard_len = 8'd3; tmo_len = 16'd100;

        // Reset state
        repeat (3) tick();
        chk("rst_change", change, 0);
        chk("rst_blank", blank, 0);
        chk("rst_sw_busy", sw_busy, 0);
        chk("rst_sw_done", sw_done, 0);
        chk("rst_sw_err", sw_err, 0);
        rst_n = 1'b1;
        tick();

        // Basic switch 0->1, guard_len=3
        sel_req = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("basic_blank", blank, (i >= 2 && i <= 6));
            chk("basic_done", sw_done, (i == 7));
            chk("basic_change", change, (i >= 7));
        end

        // Return to "_s"
        sel_req = 1'b0;
        repeat (10) tick();
        chk("back_change", change, 0);

        // Drain wait: busy_s held 10 cycles
        busy_s = 1'b1; sel_req = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sw_err) cnt++;
            if (i <= 10) chk("drain_noblank", blank, 0);
            if (i == 11) chk("drain_guard", blank, 1);
            if (i == 10) busy_s = 1'b0;
        end
        chk("drain_no_err", cnt, 0);
        chk("drain_change", change, 1);

        // Timeout: busy_n stuck, tmo_len=5
        busy_n = 1'b1; tmo_len = 16'd5; sel_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("tmo_err", sw_err, (i == 6));
            chk("tmo_busy", sw_busy, (i <= 5));
            chk("tmo_change", change, 1);
        end
        sel_req = 1'b1;
        tick();
        chk("hold_exit", sw_busy, 0);

        // Abort during DRAIN (also shows HOLD was left)
        sel_req = 1'b0;
        tick();
        chk("abort_drain_busy", sw_busy, 1);
        tick(); tick();
        sel_req = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (blank || sw_done || sw_err) cnt++;
            if (i == 1) chk("abort_idle", sw_busy, 0);
        end
        chk("abort_quiet", cnt, 0);
        chk("abort_change", change, 1);

        // sel_req reverted during GUARD: switch completes, then switches back
        busy_n = 1'b0; guard_len = 8'd5; sel_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 3) begin
                chk("ag_in_guard", blank, 1);
                sel_req = 1'b1;
            end
            if (i >= 4) begin
                chk("ag_change", change, !(i >= 9 && i < 18));
                chk("ag_done", sw_done, (i == 9 || i == 18));
            end
        end

        // Reset mid-GUARD, then a fresh sequence with sel_req still 1
        sel_req = 1'b0;
        repeat (12) tick();
        guard_len = 8'd3; sel_req = 1'b1;
        repeat (3) tick();
        chk("rg_blank_pre", blank, 1);
        rst_n = 1'b0;
        tick();
        chk("rg_change", change, 0);
        chk("rg_blank", blank, 0);
        chk("rg_busy", sw_busy, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rr_change", change, (i >= 7));
            chk("rr_busy", sw_busy, (i <= 6));
        end

        // guard_len=0: blank exactly two cycles
        guard_len = 8'd0; sel_req = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (blank) cnt++;
            if (i == 4) chk("g0_done", sw_done, 1);
        end
        chk("g0_blank_cycles", cnt, 2);
        chk("g0_change", change, 0);

        // tmo_len=0 with busy stuck: never times out
        tmo_len = 16'd0; busy_s = 1'b1; sel_req = 1'b1;
        cnt = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (sw_err) cnt++;
        end
        chk("tmo0_no_err", cnt, 0);
        chk("tmo0_still_drain", sw_busy, 1);
        sel_req = 1'b0; busy_s = 1'b0;
        tick();

        // Randomized segments, each started from reset with fixed guard/timeout
        for (int s = 0; s < 6; s++) begin
            rst_n = 1'b0;
            guard_len = 8'($urandom_range(0, 4));
            tmo_len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 15));
            tick();
            rst_n = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 9) == 0) sel_req = ~sel_req;
                if ($urandom_range(0, 5) == 0) busy_s = 1'($urandom);
                if ($urandom_range(0, 5) == 0) busy_n = 1'($urandom);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
